// File: rtl/multi_stop_cmd_ctrl_pkg.sv
// Shared types and field positions for the multi-stop command controller.
package msc_pkg;

   typedef enum logic [1:0] {
      OP_STOP   = 2'b00,
      OP_GO     = 2'b01,
      OP_APPEND = 2'b10,
      OP_SKIP   = 2'b11
   } opcode_e;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      MOVE  = 2'b01,
      DWELL = 2'b10
   } state_e;

   // BLE command byte layout: [7:6] opcode, [5:0] station ID
   localparam int CMD_W     = 8;
   localparam int CMD_OP_HI = 7;
   localparam int CMD_OP_LO = 6;
   localparam int CMD_ID_HI = 5;
   localparam int BC_ID_W   = 8;

endpackage

// File: rtl/multi_stop_cmd_ctrl_if.sv
// Command / station-ID / motion / buzzer signal bundle for the controller.
interface multi_stop_cmd_ctrl_if #(
   parameter int ID_W   = 6,
   parameter int QDEPTH = 4
) ();
   import msc_pkg::*;

   logic                        cmd_rdy;
   logic [CMD_W-1:0]            cmd;
   logic                        clr_cmd_rdy;
   logic                        ID_vld;
   logic [BC_ID_W-1:0]          ID;
   logic                        clr_ID_vld;
   logic                        ok2move;
   logic                        go;
   logic                        in_transit;
   logic                        buzz;
   logic                        buzz_n;
   logic [ID_W-1:0]             dest_id;
   logic [$clog2(QDEPTH+1)-1:0] q_cnt;
   logic                        q_ovf;
   logic                        arrived;

   // receivers / sensors / motion side
   modport master (
      output cmd_rdy, cmd, ID_vld, ID, ok2move,
      input  clr_cmd_rdy, clr_ID_vld, go, in_transit, buzz, buzz_n,
             dest_id, q_cnt, q_ovf, arrived
   );

   // controller side
   modport slave (
      input  cmd_rdy, cmd, ID_vld, ID, ok2move,
      output clr_cmd_rdy, clr_ID_vld, go, in_transit, buzz, buzz_n,
             dest_id, q_cnt, q_ovf, arrived
   );
endinterface

// File: rtl/multi_stop_cmd_ctrl_dest_fifo.sv
// Circular destination queue; flush may coincide with push (GO restarts the queue).
module dest_fifo #(
   parameter int W     = 6,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push_i,
   input  logic                       pop_i,
   input  logic                       flush_i,
   input  logic [W-1:0]               din_i,
   output logic [W-1:0]               head_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o,
   output logic                       full_o,
   output logic                       empty_o
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [W-1:0]  mem_q [DEPTH];
   logic [PW-1:0] rd_q, wr_q, wr_idx;
   logic [CW-1:0] cnt_q;

   assign full_o  = (cnt_q == CW'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign count_o = cnt_q;
   assign head_o  = empty_o ? '0 : mem_q[rd_q];
   // a flush rewinds the write slot to 0 before the accompanying push lands
   assign wr_idx  = flush_i ? '0 : wr_q;

   // pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^n)
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else if (flush_i) begin
         rd_q  <= '0;
         wr_q  <= push_i ? PW'(1) : '0;
         cnt_q <= push_i ? CW'(1) : '0;
      end else if (push_i && !full_o) begin
         wr_q  <= wr_q + 1'b1;
         cnt_q <= cnt_q + 1'b1;
      end else if (pop_i && !empty_o) begin
         rd_q  <= rd_q + 1'b1;
         cnt_q <= cnt_q - 1'b1;
      end
   end

   // storage; contents are don't-care while unoccupied since head is masked
   always_ff @(posedge clk) begin
      if (push_i && (flush_i || !full_o))
         mem_q[wr_idx] <= din_i;
   end
endmodule

// File: rtl/multi_stop_cmd_ctrl.sv
// Multi-stop delivery command processor: BLE command decode, stop sequencing,
// dwell timing at intermediate stops and blocked-path buzzer.
module multi_stop_cmd_ctrl
   import msc_pkg::*;
#(
   parameter int ID_W      = 6,
   parameter int QDEPTH    = 4,
   parameter int DWELL_CYC = 50000,
   parameter int BUZZ_DIV  = 12500
) (
   input  logic                  clk,
   input  logic                  rst,
   multi_stop_cmd_ctrl_if.slave  bus
);
   localparam int CW = $clog2(QDEPTH+1);
   localparam int DW = $clog2(DWELL_CYC+1);
   localparam int BW = $clog2(BUZZ_DIV+1);

   state_e          state_q, state_d;
   logic            ovf_q, ovf_d;
   logic            arrived_q, arrived_d;
   logic [DW-1:0]   dwell_q, dwell_d;
   logic [BW-1:0]   div_q;
   logic            ph_q;

   logic            push, pop, flush, full, empty;
   logic [ID_W-1:0] head;
   logic [CW-1:0]   cnt;
   opcode_e         op;
   logic            id_match, dwell_done;
   logic            in_transit, buzz_act, clr_cmd, clr_id, go, buzz, buzz_n;

   assign op         = opcode_e'(bus.cmd[CMD_OP_HI:CMD_OP_LO]);
   // upper BC ID bits must be clear for a match
   assign id_match   = ((bus.ID >> ID_W) == 8'd0) && (bus.ID[ID_W-1:0] == head);
   assign dwell_done = (dwell_q == DW'(DWELL_CYC-1));

   dest_fifo #(.W(ID_W), .DEPTH(QDEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .pop_i   (pop),
      .flush_i (flush),
      .din_i   (bus.cmd[ID_W-1:0]),
      .head_o  (head),
      .count_o (cnt),
      .full_o  (full),
      .empty_o (empty)
   );

   // FSM state, sticky overflow flag and registered arrival pulse
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         ovf_q     <= 1'b0;
         arrived_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ovf_q     <= ovf_d;
         arrived_q <= arrived_d;
      end
   end

   // next state and queue control; a pending command always beats a pending ID
   always_comb begin
      state_d   = state_q;
      ovf_d     = ovf_q;
      arrived_d = 1'b0;
      push      = 1'b0;
      pop       = 1'b0;
      flush     = 1'b0;
      if (bus.cmd_rdy) begin
         case (op)
            OP_STOP: begin
               flush   = 1'b1;
               ovf_d   = 1'b0;
               state_d = IDLE;
            end
            OP_GO: begin
               flush   = 1'b1;
               push    = 1'b1;
               state_d = MOVE;
            end
            OP_APPEND: begin
               if (!full) push = 1'b1;
               else       ovf_d = 1'b1;
               // APPEND does not disturb an ongoing dwell
               if (state_q == IDLE && empty)        state_d = MOVE;
               else if (state_q == DWELL && dwell_done) state_d = MOVE;
            end
            default: begin // OP_SKIP
               pop     = !empty;
               state_d = (cnt <= CW'(1)) ? IDLE : MOVE;
            end
         endcase
      end else begin
         case (state_q)
            MOVE: begin
               if (bus.ID_vld && id_match) begin
                  pop       = 1'b1;
                  arrived_d = 1'b1;
                  state_d   = (cnt == CW'(1)) ? IDLE : DWELL;
               end
            end
            DWELL:   if (dwell_done) state_d = MOVE;
            default: state_d = state_q;
         endcase
      end
      // counter runs only while staying in DWELL, so each entry starts from 0
      dwell_d = (state_q == DWELL && state_d == DWELL) ? dwell_q + 1'b1 : '0;
   end

   // handshakes and motion/buzzer drive
   always_comb begin
      in_transit = (state_q == MOVE);
      clr_cmd    = bus.cmd_rdy;
      clr_id     = bus.ID_vld & ~bus.cmd_rdy;
      go         = in_transit & bus.ok2move;
      buzz_act   = in_transit & ~bus.ok2move;
      buzz       = buzz_act & ~ph_q;
      buzz_n     = buzz_act &  ph_q;
   end

   // dwell counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) dwell_q <= '0;
      else     dwell_q <= dwell_d;
   end

   // buzzer divider; phase 0 (buzz high) on the first blocked cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_q <= '0;
         ph_q  <= 1'b0;
      end else if (!buzz_act) begin
         div_q <= '0;
         ph_q  <= 1'b0;
      end else if (div_q == BW'(BUZZ_DIV-1)) begin
         div_q <= '0;
         ph_q  <= ~ph_q;
      end else begin
         div_q <= div_q + 1'b1;
      end
   end

   assign bus.clr_cmd_rdy = clr_cmd;
   assign bus.clr_ID_vld  = clr_id;
   assign bus.go          = go;
   assign bus.in_transit  = in_transit;
   assign bus.buzz        = buzz;
   assign bus.buzz_n      = buzz_n;
   assign bus.dest_id     = head;
   assign bus.q_cnt       = cnt;
   assign bus.q_ovf       = ovf_q;
   assign bus.arrived     = arrived_q;
endmodule
